// File: rtl/cmd_reader.sv
// UART 8N1 receiver feeding a command-line assembler: collects printable bytes
// until carriage return and reports the result over an enable/state/done handshake.
module cmd_reader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int CMD_LEN      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 enable,
  output logic [8*CMD_LEN-1:0] cmd_data,
  output logic [3:0]           cmd_len,
  output logic [1:0]           reader_state,
  output logic                 reader_done,
  output logic [1:0]           reader_error
);

  localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LP_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  LP_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LP_MAX_LEN = 4'(CMD_LEN);
  localparam logic [7:0]        LP_CR      = 8'h0D;
  localparam logic [7:0]        LP_LF      = 8'h0A;

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_READ = 2'd1, RD_DONE = 2'd2, RD_ERROR = 2'd3} rd_state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_FRAMING = 2'd1, ERR_OVERFLOW = 2'd2} rd_err_t;

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  bit_state_t           r_bit_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_byte_valid;
  logic                 r_frame_err;
  rd_state_t            r_state;
  rd_err_t              r_err;
  logic [3:0]           r_cmd_len;
  logic [8*CMD_LEN-1:0] r_cmd_data;
  logic                 r_done;

  // NOTE: clocked state uses <= so every flop samples pre-edge values; blocking
  // assignments here would make ordering between always_ff blocks matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Bit engine: free-running, centre-samples each bit from the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_state  <= BIT_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_bit_state)
        BIT_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!r_rx_sync) r_bit_state <= BIT_START;
        end
        BIT_START: begin
          if (r_cnt == LP_HALF_M1) begin
            r_cnt       <= '0;
            r_bit_state <= r_rx_sync ? BIT_IDLE : BIT_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BIT_DATA: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_bit_state <= BIT_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BIT_STOP: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt        <= '0;
            r_byte_valid <= r_rx_sync;
            r_frame_err  <= ~r_rx_sync;
            r_bit_state  <= BIT_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_bit_state <= BIT_IDLE;
      endcase
    end
  end

  // NOTE: the command buffer is reset explicitly because its contents are a
  // visible output; a pure storage array would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RD_IDLE;
      r_err      <= ERR_NONE;
      r_cmd_len  <= '0;
      r_cmd_data <= '0;
      r_done     <= 1'b0;
    end else if (!enable) begin
      r_state <= RD_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_state    <= RD_READ;
          r_err      <= ERR_NONE;
          r_cmd_len  <= '0;
          r_cmd_data <= '0;
          r_done     <= 1'b0;
        end
        RD_READ: begin
          if (r_byte_valid) begin
            if (r_shift == LP_CR) begin
              if (r_cmd_len != 4'd0) begin
                r_state <= RD_DONE;
                r_done  <= 1'b1;
              end
            end else if (r_shift != LP_LF) begin
              if (r_cmd_len < LP_MAX_LEN) begin
                for (int i = 0; i < CMD_LEN; i++) begin
                  if (r_cmd_len == 4'(i)) r_cmd_data[8*i +: 8] <= r_shift;
                end
                r_cmd_len <= r_cmd_len + 1'b1;
              end else begin
                r_state <= RD_ERROR;
                r_err   <= ERR_OVERFLOW;
                r_done  <= 1'b1;
              end
            end
          end else if (r_frame_err) begin
            r_state <= RD_ERROR;
            r_err   <= ERR_FRAMING;
            r_done  <= 1'b1;
          end
        end
        default: ;  // DONE and ERROR hold until enable drops
      endcase
    end
  end

  assign cmd_data     = r_cmd_data;
  assign cmd_len      = r_cmd_len;
  assign reader_state = r_state;
  assign reader_done  = r_done;
  assign reader_error = r_err;

endmodule

// File: tb/tb_cmd_reader.sv
// Scoreboard bench for cmd_reader: expected completions are queued by the stimulus
// and compared by a monitor on each rising reader_done; directed checks cover the rest.
module tb_cmd_reader;

  localparam int CPB = 16;
  localparam int CL  = 8;

  logic          clk;
  logic          rst;
  logic          rx;
  logic          enable;
  logic [63:0]   cmd_data;
  logic [3:0]    cmd_len;
  logic [1:0]    reader_state;
  logic          reader_done;
  logic [1:0]    reader_error;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  err;
    logic [3:0]  len;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_failures = 0;
  logic prev_done  = 1'b0;

  cmd_reader #(.CLKS_PER_BIT(CPB), .CMD_LEN(CL)) dut (
    .clk(clk), .rst(rst), .rx(rx), .enable(enable),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .reader_state(reader_state),
    .reader_done(reader_done), .reader_error(reader_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising reader_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && reader_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(reader_state), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_state", 64'(reader_state), 64'(e.st));
        check("sb_error", 64'(reader_error), 64'(e.err));
        check("sb_len",   64'(cmd_len),      64'(e.len));
        check("sb_data",  cmd_data,          e.data);
      end
    end
    prev_done = reader_done;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_bit;
    cycles(CPB);
    rx = 1'b1;
    cycles(4);
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [1:0] err,
                          input logic [3:0] len, input logic [63:0] data);
    exp_t e;
    e.st = st; e.err = err; e.len = len; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400 && !reader_done; k++) @(negedge clk);
    if (!reader_done) check(name, 64'(reader_done), 64'd1);
    cycles(2);
  endtask

  task automatic start_read();
    enable = 1'b1;
    cycles(2);
  endtask

  task automatic stop_read();
    enable = 1'b0;
    cycles(2);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx = 1'b1;
    cycles(5);
    check("rst_state", 64'(reader_state), 64'd0);
    check("rst_done",  64'(reader_done),  64'd0);
    check("rst_error", 64'(reader_error), 64'd0);
    check("rst_len",   64'(cmd_len),      64'd0);
    check("rst_data",  cmd_data,          64'd0);
    rst = 1'b0;
    cycles(3);

    // Normal command "ls\r"
    start_read();
    check("enter_read", 64'(reader_state), 64'd1);
    push_exp(2'd2, 2'd0, 4'd2, 64'h736C);
    send_byte(8'h6C); send_byte(8'h73); send_byte(8'h0D);
    wait_done("ls_timeout");
    enable = 1'b0;
    @(negedge clk);
    check("ls_idle_1cyc", 64'(reader_state), 64'd0);
    check("ls_done_low",  64'(reader_done),  64'd0);
    check("ls_retained",  cmd_data,          64'h736C);
    check("ls_len_kept",  64'(cmd_len),      64'd2);
    cycles(2);

    // Empty lines then "a\r"
    start_read();
    send_byte(8'h0D);
    check("cr_empty_read", 64'(reader_state), 64'd1);
    send_byte(8'h0A);
    check("lf_read", 64'(reader_state), 64'd1);
    check("lf_len",  64'(cmd_len),      64'd0);
    push_exp(2'd2, 2'd0, 4'd1, 64'h61);
    send_byte(8'h61); send_byte(8'h0D);
    wait_done("a_timeout");
    stop_read();

    // Overflow: nine 'x'
    start_read();
    push_exp(2'd3, 2'd2, 4'd8, 64'h7878787878787878);
    for (int i = 0; i < 8; i++) send_byte(8'h78);
    check("full_still_read", 64'(reader_state), 64'd1);
    send_byte(8'h78);
    wait_done("ovf_timeout");
    send_byte(8'h0D);
    check("err_holds", 64'(reader_state), 64'd3);
    stop_read();

    // Framing error
    start_read();
    push_exp(2'd3, 2'd1, 4'd0, 64'h0);
    send_byte(8'h41, 1'b0);
    wait_done("frm_timeout");
    stop_read();
    cycles(200);

    // Glitch, then disabled input
    start_read();
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(40);
    check("glitch_state", 64'(reader_state), 64'd1);
    check("glitch_len",   64'(cmd_len),      64'd0);
    stop_read();
    send_byte(8'h78); send_byte(8'h0D);
    check("dis_state", 64'(reader_state), 64'd0);
    check("dis_done",  64'(reader_done),  64'd0);
    check("dis_len",   64'(cmd_len),      64'd0);
    check("dis_data",  cmd_data,          64'd0);

    // Reset mid-frame: buffer 'k', then reset during data bit 4 of 'q'
    start_read();
    send_byte(8'h6B);
    check("pre_rst_len", 64'(cmd_len), 64'd1);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h71 >> i) & 8'h1;
      cycles(CPB);
    end
    rx = 1'b1;
    cycles(CPB / 2);
    rst = 1'b1; enable = 1'b0;
    cycles(2);
    check("mrst_state", 64'(reader_state), 64'd0);
    check("mrst_done",  64'(reader_done),  64'd0);
    check("mrst_error", 64'(reader_error), 64'd0);
    check("mrst_len",   64'(cmd_len),      64'd0);
    check("mrst_data",  cmd_data,          64'd0);
    rst = 1'b0;
    cycles(30);
    start_read();
    push_exp(2'd2, 2'd0, 4'd1, 64'h71);
    send_byte(8'h71); send_byte(8'h0D);
    wait_done("q_timeout");
    stop_read();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/cmd_reader.md
# cmd_reader

UART receive path and command-line assembler for the serial command interface, the receive-side counterpart of the transmit/printer chain. It deserialises 8N1 frames on `rx`, collects printable bytes into a CMD_LEN-byte buffer and terminates a command on carriage return. It uses the same enable/state/done handshake as the other sub-blocks so the top-level FSM can run it as its command-read state.

## Interface
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be ≥ 8
- CMD_LEN, 8, maximum command length in bytes; must be ≤ 15
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous UART line, idle high
- enable  in  1  high = accept a command; low = abort/idle
- cmd_data  out  8*CMD_LEN  received bytes; byte i at [8i+7:8i], byte 0 first received; unused bytes 0
- cmd_len  out  4  number of valid bytes in cmd_data
- reader_state  out  2  0 IDLE, 1 READ, 2 DONE, 3 ERROR
- reader_done  out  1  high while reader_state is DONE or ERROR
- reader_error  out  2  0 none, 1 framing, 2 overflow

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- The bit engine (BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP) runs regardless of `enable`.
  - BIT_IDLE: a synchronised low enters BIT_START.
  - BIT_START: after CLKS_PER_BIT/2 cycles (integer division), rx is sampled. Low goes to BIT_DATA; high is a glitch and returns to BIT_IDLE with no byte.
  - BIT_DATA: 8 samples, each CLKS_PER_BIT cycles apart, shifted in LSB first.
  - BIT_STOP: sampled CLKS_PER_BIT after the last data bit. High produces a one-cycle byte_valid; low produces a one-cycle frame_err. The engine returns to BIT_IDLE the same cycle.
- Reader FSM:
  - IDLE: enable=1 moves to READ and clears cmd_data, cmd_len and reader_error.
  - READ, on byte_valid:
    - 0x0D with cmd_len=0: ignored.
    - 0x0D with cmd_len>0: go to DONE.
    - 0x0A: ignored.
    - Any other byte with cmd_len<CMD_LEN: stored at index cmd_len, cmd_len+1.
    - Any other byte with cmd_len=CMD_LEN: go to ERROR, reader_error=2.
  - READ, on frame_err: go to ERROR, reader_error=1.
  - DONE / ERROR: hold all outputs and ignore further bytes.
  - Any state with enable=0: go to IDLE next cycle. cmd_data, cmd_len and reader_error keep their values until the next IDLE→READ.
- Bytes completing while the FSM is not in READ are discarded. This covers a frame already in flight when enable rises: it counts only if its stop bit is sampled in READ.
- Reset: reader_state=0, reader_done=0, reader_error=0, cmd_len=0, cmd_data=0, bit engine in BIT_IDLE, counters 0. Reset mid-frame drops the partial byte.

## Timing
- Synchroniser latency: 2 cycles.
- Sample points relative to the first synchronised low: start bit at +CLKS_PER_BIT/2, data bit k at +CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT, stop bit at +CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- byte_valid/frame_err is asserted in the cycle after the stop sample. reader_state/reader_done/reader_error update one cycle after that.
- A new start edge is detectable from the cycle after the stop sample, giving half a bit of margin.
- IDLE→READ takes 1 cycle after enable=1. Any state→IDLE takes 1 cycle after enable=0.
- reader_done stays high until enable is deasserted. This is a level handshake: the owner holds enable until done, then drops it.
- Simultaneous enable=0 and byte_valid: enable wins; the byte is discarded and the FSM goes to IDLE.

## Test plan
Benches use CLKS_PER_BIT=16, CMD_LEN=8.

- Normal command: enable=1, send "ls\r" → DONE, reader_done=1, cmd_len=2, cmd_data[15:0]=0x736C, reader_error=0. Then enable=0 → IDLE next cycle, cmd_data retained.
- Empty lines: send "\r\n", then "a\r" → stays READ through the CR and LF. DONE only after the second CR: cmd_len=1, cmd_data[7:0]=0x61.
- Overflow: send 9× 0x78 → after the 9th stop bit, ERROR with reader_error=2, cmd_len=8, cmd_data=0x7878787878787878.
- Framing error: send 0x41 with the stop bit driven low → ERROR, reader_error=1, cmd_len=0.
- Glitch and disabled input: hold rx low for 3 cycles → no byte and state stays READ. With enable=0, send "x\r" → state stays IDLE, outputs unchanged.
- Reset mid-frame: assert rst during data bit 4 → all outputs 0. Release, enable=1, send "q\r" → DONE, cmd_len=1, cmd_data[7:0]=0x71.
